lc3_mem_responder: RTL
======================

Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 control/datapath. It services the read and write transactions that the control FSM initiates via MAR/MDR loads.
- Fronts a synchronous SRAM with a programmable number of wait states, and implements the LC-3 memory-mapped I/O registers: KBSR/KBDR, DSR/DDR and MCR.
- The top level holds the control FSM's `enable` low while `busy` is high, which stalls the FSM during memory access.

Parameters:
- WAIT_STATES, 1, extra SRAM cycles between address issue and read-data valid; legal range 0..7.
- KBD_W, 8, width of the keyboard/display character path.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  transaction request; held high until resp_done.
- req_we  input  1  1 = write, 0 = read; stable while req_valid.
- req_addr  input  16  word address (MAR).
- req_wdata  input  16  write data (MDR).
- busy  output  1  transaction in progress; gates control enable.
- resp_done  output  1  one-cycle pulse that completes the transaction.
- resp_rdata  output  16  read data, valid with resp_done; holds its value until the next resp_done.
- sram_en  output  1  SRAM access strobe.
- sram_we  output  1  SRAM write strobe.
- sram_addr  output  16  SRAM address.
- sram_wdata  output  16  SRAM write data.
- sram_rdata  input  16  SRAM read data, valid WAIT_STATES+1 cycles after sram_en.
- kbd_valid  input  1  keyboard character available.
- kbd_data  input  KBD_W  keyboard character.
- kbd_ready  output  1  = ~KBSR[15]; character accepted when kbd_valid & kbd_ready.
- dsp_valid  output  1  display character pending.
- dsp_data  output  KBD_W  display character (DDR low bits).
- dsp_ready  input  1  display consumes the character when dsp_valid & dsp_ready.
- halted  output  1  = ~MCR[15].
- irq  output  1  keyboard interrupt (see Optional Feature).

Behaviour:
- Reset values (async, reset low):
  - state = IDLE; busy=0, resp_done=0, resp_rdata=0.
  - sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - KBSR=0, KBDR=0.
  - DSR=0x8000, DDR=0, dsp_valid=0.
  - MCR=0x8000, so halted=0; irq=0.
- Address map:
  - 0xFE00 KBSR, 0xFE02 KBDR, 0xFE04 DSR, 0xFE06 DDR, 0xFFFE MCR.
  - Any other address >= 0xFE00 is unmapped: reads return 0, writes are ignored, and SRAM is never touched.
  - Addresses < 0xFE00 go to SRAM.
- FSM states: IDLE, SRAM_ISSUE, SRAM_WAIT, MMIO, DONE.
- IDLE:
  - On req_valid, register addr/we/wdata and set busy=1.
  - Go to MMIO if addr >= 0xFE00, else SRAM_ISSUE.
- SRAM_ISSUE:
  - sram_en=1 for exactly one cycle; sram_we=req_we.
  - Load the wait counter with WAIT_STATES.
  - Go to SRAM_WAIT if WAIT_STATES>0, else DONE.
- SRAM_WAIT: decrement the counter; at 1, go to DONE.
- MMIO: perform the register read or write; go to DONE.
- DONE:
  - resp_done=1 for one cycle; for reads, resp_rdata captures sram_rdata or the MMIO value.
  - busy falls in the same cycle; go to IDLE.
  - The next req_valid is accepted no earlier than the following cycle.
- Latency from the req_valid accept edge to resp_done:
  - SRAM: WAIT_STATES+2 cycles.
  - MMIO: 2 cycles.
- Keyboard:
  - Accept kbd_valid & kbd_ready: KBDR = {8'h0, kbd_data}, KBSR[15]=1.
  - A read of KBDR clears KBSR[15] in the MMIO cycle. A character arriving that same cycle is not accepted, because kbd_ready=0.
  - Writes to KBDR are ignored. A write to KBSR affects only bit 14 (when the feature is enabled).
- Display:
  - A write to DDR while DSR[15]=1 latches DDR, clears DSR[15] and sets dsp_valid.
  - A write to DDR while DSR[15]=0 is dropped silently.
  - On dsp_valid & dsp_ready: dsp_valid=0 and DSR[15]=1 in the next cycle.
  - Writes to DSR are ignored.
- MCR:
  - A write stores the full word; writing bit15=0 sets halted.
  - Only reset clears halted. The responder itself keeps servicing requests while halted.
- Reset asserted mid-transaction aborts it immediately. No resp_done is issued and sram_en is forced to 0.
- req_valid dropped before resp_done is a protocol violation; the transaction completes anyway.

Optional Feature:
- Macro: LC3_MEM_KBIE_EN.
- Defined:
  - KBSR[14] is a read/write interrupt-enable bit.
  - irq = KBSR[15] & KBSR[14], registered, so it updates one cycle after either bit changes.
- Undefined:
  - KBSR[14] reads 0 and writes to it are ignored.
  - irq is tied 0.
  - The irq port exists in both builds.

Decomposition:
- Shared package lc3_pkg:
  - MMIO address constants: ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR, ADDR_MCR, MMIO_BASE=0xFE00.
  - Responder state encoding.
  - Status bit indices: READY_BIT=15, IE_BIT=14, CLKEN_BIT=15.
- Sub-module lc3_mmio_regs:
  - Holds KBSR/KBDR/DSR/DDR/MCR, the kbd/dsp handshakes and irq.
  - Driven by a one-cycle access strobe from the FSM.

Test Plan:
- WAIT_STATES=2: read 0x3000, SRAM returns 0x1234 -> sram_en one cycle, resp_done 4 cycles after accept, resp_rdata=0x1234, busy high for exactly those cycles.
- Write 0x4000 data 0xBEEF -> sram_we=1 with sram_en for one cycle, sram_addr=0x4000, sram_wdata=0xBEEF; then an immediate read of 0x4000 returns 0xBEEF.
- kbd_valid with data 0x41 -> KBSR reads 0x8000 and kbd_ready=0; a second character 0x42 is refused; KBDR read returns 0x0041, then KBSR reads 0x0000 and 0x42 is accepted next cycle.
- Write DDR 0x0058 with dsp_ready=0 -> dsp_valid=1 and DSR reads 0x0000; a second DDR write of 0x0059 is dropped; dsp_ready pulse -> dsp_data=0x58 consumed, DSR reads 0x8000.
- Write MCR 0x0000 -> halted=1; a read of 0xFE10 returns 0 with no sram_en; reset low mid-SRAM-wait -> halted=0, busy=0, no resp_done.
- LC3_MEM_KBIE_EN defined: write KBSR 0x4000, then a key arrives -> irq=1 one cycle later; KBDR read -> irq=0. Undefined: irq stays 0 and KBSR bit14 reads 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory responder: MMIO address map,
// responder state encoding and status-register bit positions.
package lc3_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  localparam int unsigned READY_BIT = 15;
  localparam int unsigned IE_BIT    = 14;
  localparam int unsigned CLKEN_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SRAM_ISSUE = 3'd1,
    ST_SRAM_WAIT  = 3'd2,
    ST_MMIO       = 3'd3,
    ST_DONE       = 3'd4
  } resp_state_t;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr >= MMIO_BASE);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 memory-mapped device registers (KBSR/KBDR, DSR/DDR, MCR) with the
// keyboard/display handshakes. Optional interrupt enable: LC3_MEM_KBIE_EN.
module lc3_mmio_regs
  import lc3_pkg::*;
#(
  parameter int unsigned KBD_W = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_acc,
  input  logic             i_we,
  input  logic [15:0]      i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  input  logic             i_kbd_valid,
  input  logic [KBD_W-1:0] i_kbd_data,
  output logic             o_kbd_ready,
  output logic             o_dsp_valid,
  output logic [KBD_W-1:0] o_dsp_data,
  input  logic             i_dsp_ready,
  output logic             o_halted,
  output logic             o_irq
);

  logic        r_kb_ready;
  logic [15:0] r_kbdr;
  logic        r_ds_ready;
  logic [15:0] r_ddr;
  logic        r_dsp_valid;
  logic [15:0] r_mcr;

  logic        w_rd_kbdr;
  logic        w_wr_ddr;
  logic        w_wr_mcr;
  logic        w_kbd_take;
  logic        w_kb_ie;
  logic [15:0] w_kbsr;
  logic [15:0] w_mcr_next;

  assign w_rd_kbdr  = i_acc & ~i_we & (i_addr == ADDR_KBDR);
  assign w_wr_ddr   = i_acc &  i_we & (i_addr == ADDR_DDR);
  assign w_wr_mcr   = i_acc &  i_we & (i_addr == ADDR_MCR);
  assign w_kbd_take = i_kbd_valid & ~r_kb_ready;

  // An accepted key wins over a KBDR read; the read can only collide with
  // an accept when the buffer was already empty, so nothing is lost.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kb_ready <= 1'b0;
      r_kbdr     <= '0;
    end else if (w_kbd_take) begin
      r_kb_ready <= 1'b1;
      r_kbdr     <= 16'(i_kbd_data);
    end else if (w_rd_kbdr) begin
      r_kb_ready <= 1'b0;
    end
  end

`ifdef LC3_MEM_KBIE_EN
  logic r_kb_ie;
  logic r_irq;
  logic w_wr_kbsr;

  assign w_wr_kbsr = i_acc & i_we & (i_addr == ADDR_KBSR);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kb_ie <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_kbsr) r_kb_ie <= i_wdata[IE_BIT];
      r_irq <= r_kb_ready & r_kb_ie;
    end
  end

  assign w_kb_ie = r_kb_ie;
  assign o_irq   = r_irq;
`else
  assign w_kb_ie = 1'b0;
  assign o_irq   = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ds_ready  <= 1'b1;
      r_ddr       <= '0;
      r_dsp_valid <= 1'b0;
    end else if (w_wr_ddr && r_ds_ready) begin
      r_ddr       <= i_wdata;
      r_ds_ready  <= 1'b0;
      r_dsp_valid <= 1'b1;
    end else if (r_dsp_valid && i_dsp_ready) begin
      r_ds_ready  <= 1'b1;
      r_dsp_valid <= 1'b0;
    end
  end

  // Clock-enable bit is sticky-low: once halted, only reset restarts it.
  always_comb begin
    w_mcr_next            = i_wdata;
    w_mcr_next[CLKEN_BIT] = r_mcr[CLKEN_BIT] & i_wdata[CLKEN_BIT];
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcr <= 16'h8000;
    end else if (w_wr_mcr) begin
      r_mcr <= w_mcr_next;
    end
  end

  always_comb begin
    w_kbsr            = '0;
    w_kbsr[READY_BIT] = r_kb_ready;
    w_kbsr[IE_BIT]    = w_kb_ie;
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_KBSR: o_rdata = w_kbsr;
      ADDR_KBDR: o_rdata = r_kbdr;
      ADDR_DSR:  o_rdata[READY_BIT] = r_ds_ready;
      ADDR_DDR:  o_rdata = r_ddr;
      ADDR_MCR:  o_rdata = r_mcr;
      default:   o_rdata = '0;
    endcase
  end

  assign o_kbd_ready = ~r_kb_ready;
  assign o_dsp_valid = r_dsp_valid;
  assign o_dsp_data  = r_ddr[KBD_W-1:0];
  assign o_halted    = ~r_mcr[CLKEN_BIT];

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: SRAM front end with programmable wait states plus
// the MMIO register block. Optional keyboard interrupt: LC3_MEM_KBIE_EN.
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned KBD_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_wdata,
  output logic             busy,
  output logic             resp_done,
  output logic [15:0]      resp_rdata,
  output logic             sram_en,
  output logic             sram_we,
  output logic [15:0]      sram_addr,
  output logic [15:0]      sram_wdata,
  input  logic [15:0]      sram_rdata,
  input  logic             kbd_valid,
  input  logic [KBD_W-1:0] kbd_data,
  output logic             kbd_ready,
  output logic             dsp_valid,
  output logic [KBD_W-1:0] dsp_data,
  input  logic             dsp_ready,
  output logic             halted,
  output logic             irq
);

  localparam logic [2:0] WS = WAIT_STATES[2:0];

  resp_state_t r_state;
  logic [15:0] r_addr;
  logic        r_we;
  logic [15:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [15:0] r_rdata;

  logic [15:0] w_mmio_rdata;
  logic        w_mmio_acc;
  logic        w_sram_rd_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_state <= is_mmio(req_addr) ? ST_MMIO : ST_SRAM_ISSUE;
          end
        end
        ST_SRAM_ISSUE: begin
          r_cnt   <= WS;
          r_state <= (WS != 3'd0) ? ST_SRAM_WAIT : ST_DONE;
        end
        ST_SRAM_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) r_state <= ST_DONE;
        end
        ST_MMIO: begin
          if (!r_we) r_rdata <= w_mmio_rdata;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_sram_rd_done) r_rdata <= sram_rdata;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM read data arrives during DONE, so it is forwarded combinationally
  // for that cycle and held in r_rdata afterwards.
  assign w_sram_rd_done = (r_state == ST_DONE) & ~r_we & ~is_mmio(r_addr);
  assign resp_rdata     = w_sram_rd_done ? sram_rdata : r_rdata;

  assign busy       = r_state inside {ST_SRAM_ISSUE, ST_SRAM_WAIT, ST_MMIO};
  assign resp_done  = (r_state == ST_DONE);
  assign sram_en    = (r_state == ST_SRAM_ISSUE);
  assign sram_we    = sram_en & r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign w_mmio_acc = (r_state == ST_MMIO);

  lc3_mmio_regs #(
    .KBD_W (KBD_W)
  ) u_mmio (
    .clk         (clk),
    .i_rst_n     (reset),
    .i_acc       (w_mmio_acc),
    .i_we        (r_we),
    .i_addr      (r_addr),
    .i_wdata     (r_wdata),
    .o_rdata     (w_mmio_rdata),
    .i_kbd_valid (kbd_valid),
    .i_kbd_data  (kbd_data),
    .o_kbd_ready (kbd_ready),
    .o_dsp_valid (dsp_valid),
    .o_dsp_data  (dsp_data),
    .i_dsp_ready (dsp_ready),
    .o_halted    (halted),
    .o_irq       (irq)
  );

endmodule
